mem_port_arbiter: RTL and testbench

Shares the single data-memory port between the CPU control FSM (requester C) and the loader/debug unit (requester D). It issues at most one access per cycle and bounds CPU starvation of D with a burst limit. It provides an exclusive lock mode that drains in-flight reads before D takes sole ownership. Read data is routed back to the owning requester after the memory's fixed read latency.

---
 rtl/mem_port_arbiter.sv | 249 ++++++++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//
// Shares one data-memory port between the CPU control FSM (requester C) and
// the loader/debug unit (requester D). At most one access is issued per cycle.
// C wins by default. After MAX_BURST consecutive C grants with D waiting, D is
// granted once. Raising i_d_lock drains in-flight reads and then gives D sole
// ownership until i_d_lock drops. Read data is steered back to the requester
// that issued the read, RD_LAT cycles after the grant.
//
// Optional feature macro: ARB_PERF_EN
//   defined   : 16-bit saturating count of cycles with C requesting but not
//               granted, driven on o_perf_stall
//   undefined : no counter, o_perf_stall tied to 0
//
// Ports
//   clk, rst                    clock, synchronous active-high reset
//   i_c_req/we/addr/wdata       C request, write enable, address, write data
//   o_c_gnt                     C access issued this cycle
//   o_c_rvalid, o_c_rdata       C read response
//   i_d_* / o_d_*               same as C, for D
//   i_d_lock                    D requests exclusive ownership
//   o_lock_ack                  high while D owns the port exclusively
//   o_mem_en/we/addr/wdata      memory request
//   i_mem_rdata                 memory read data, valid RD_LAT cycles after issue
//   o_perf_stall                C stall counter (see ARB_PERF_EN)

module mem_port_arbiter #(
    parameter int unsigned AW        = 16,
    parameter int unsigned DW        = 16,
    parameter int unsigned RD_LAT    = 1,
    parameter int unsigned MAX_BURST = 4
) (
    input  logic          clk,
    input  logic          rst,

    input  logic          i_c_req,
    input  logic          i_c_we,
    input  logic [AW-1:0] i_c_addr,
    input  logic [DW-1:0] i_c_wdata,
    output logic          o_c_gnt,
    output logic          o_c_rvalid,
    output logic [DW-1:0] o_c_rdata,

    input  logic          i_d_req,
    input  logic          i_d_we,
    input  logic [AW-1:0] i_d_addr,
    input  logic [DW-1:0] i_d_wdata,
    output logic          o_d_gnt,
    output logic          o_d_rvalid,
    output logic [DW-1:0] o_d_rdata,

    input  logic          i_d_lock,
    output logic          o_lock_ack,

    output logic          o_mem_en,
    output logic          o_mem_we,
    output logic [AW-1:0] o_mem_addr,
    output logic [DW-1:0] o_mem_wdata,
    input  logic [DW-1:0] i_mem_rdata,

    output logic [15:0]   o_perf_stall
);

    localparam int unsigned   BW        = $clog2(MAX_BURST + 1);
    localparam logic [BW-1:0] BURST_MAX = BW'(MAX_BURST);

    typedef enum logic [1:0] {
        StArb,
        StDrain,
        StLocked
    } state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [BW-1:0]   r_burst_cnt;
    logic [BW-1:0]   w_burst_cnt_next;
    logic            w_burst_full;

    // Read tag pipeline: stage RD_LAT-1 lines up with i_mem_rdata.
    // Owner bit: 0 = C, 1 = D.
    logic [RD_LAT-1:0] r_tag_vld;
    logic [RD_LAT-1:0] r_tag_own;
    logic              w_pipe_empty;

    logic            w_c_gnt;
    logic            w_d_gnt;
    logic            w_mem_en;
    logic            w_mem_we;
    logic [AW-1:0]   w_mem_addr;
    logic [DW-1:0]   w_mem_wdata;
    logic            w_rd_issue;
    logic            w_rsp_vld;
    logic            w_rsp_own;

    assign w_burst_full = (r_burst_cnt == BURST_MAX);
    assign w_pipe_empty = ~|r_tag_vld;

    // ------------------------------------------------------------------
    // Arbitration FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= StArb;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_c_gnt      = 1'b0;
        w_d_gnt      = 1'b0;
        unique case (r_state)
            StArb: begin
                // A lock request suppresses all grants so no new read can
                // enter the pipeline while we head into the drain.
                if (i_d_lock) begin
                    w_state_next = StDrain;
                end else if (i_c_req && !(i_d_req && w_burst_full)) begin
                    w_c_gnt = 1'b1;
                end else if (i_d_req) begin
                    w_d_gnt = 1'b1;
                end
            end
            StDrain: begin
                if (!i_d_lock) begin
                    w_state_next = StArb;
                end else if (w_pipe_empty) begin
                    w_state_next = StLocked;
                end
            end
            StLocked: begin
                w_d_gnt = i_d_req;
                if (!i_d_lock) begin
                    w_state_next = StArb;
                end
            end
            default: begin
                w_state_next = StArb;
            end
        endcase
        // Nothing is issued while reset is held.
        if (rst) begin
            w_c_gnt      = 1'b0;
            w_d_gnt      = 1'b0;
            w_state_next = StArb;
        end
    end

    // ------------------------------------------------------------------
    // Burst limiter: counts C grants that D has been waiting through
    // ------------------------------------------------------------------
    always_comb begin
        w_burst_cnt_next = r_burst_cnt;
        if (w_d_gnt || !i_d_req) begin
            w_burst_cnt_next = '0;
        end else if (w_c_gnt && !w_burst_full) begin
            w_burst_cnt_next = r_burst_cnt + BW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_burst_cnt <= '0;
        end else begin
            r_burst_cnt <= w_burst_cnt_next;
        end
    end

    // ------------------------------------------------------------------
    // Issue path
    // ------------------------------------------------------------------
    assign w_mem_en = w_c_gnt | w_d_gnt;

    always_comb begin
        w_mem_we    = 1'b0;
        w_mem_addr  = '0;
        w_mem_wdata = '0;
        if (w_c_gnt) begin
            w_mem_we    = i_c_we;
            w_mem_addr  = i_c_addr;
            w_mem_wdata = i_c_wdata;
        end else if (w_d_gnt) begin
            w_mem_we    = i_d_we;
            w_mem_addr  = i_d_addr;
            w_mem_wdata = i_d_wdata;
        end
    end

    assign w_rd_issue = w_mem_en & ~w_mem_we;

    // ------------------------------------------------------------------
    // Read tag pipeline
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tag_vld <= '0;
            r_tag_own <= '0;
        end else begin
            r_tag_vld[0] <= w_rd_issue;
            r_tag_own[0] <= w_d_gnt;
            for (int i = 1; i < int'(RD_LAT); i++) begin
                r_tag_vld[i] <= r_tag_vld[i-1];
                r_tag_own[i] <= r_tag_own[i-1];
            end
        end
    end

    // Masked by rst so a response due in the reset cycle is dropped too.
    assign w_rsp_vld = r_tag_vld[RD_LAT-1] & ~rst;
    assign w_rsp_own = r_tag_own[RD_LAT-1];

    // ------------------------------------------------------------------
    // Optional stall counter
    // ------------------------------------------------------------------
`ifdef ARB_PERF_EN
    logic [15:0] r_perf_stall;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_perf_stall <= '0;
        end else if (i_c_req && !w_c_gnt && (r_perf_stall != 16'hFFFF)) begin
            r_perf_stall <= r_perf_stall + 16'd1;
        end
    end

    assign o_perf_stall = rst ? 16'd0 : r_perf_stall;
`else
    assign o_perf_stall = 16'd0;
`endif

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign o_c_gnt     = w_c_gnt;
    assign o_d_gnt     = w_d_gnt;
    assign o_mem_en    = w_mem_en;
    assign o_mem_we    = w_mem_we;
    assign o_mem_addr  = w_mem_addr;
    assign o_mem_wdata = w_mem_wdata;

    assign o_c_rvalid  = w_rsp_vld & ~w_rsp_own;
    assign o_d_rvalid  = w_rsp_vld &  w_rsp_own;
    assign o_c_rdata   = o_c_rvalid ? i_mem_rdata : '0;
    assign o_d_rdata   = o_d_rvalid ? i_mem_rdata : '0;

    assign o_lock_ack  = (r_state == StLocked) & ~rst;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

    localparam int unsigned AW        = 16;
    localparam int unsigned DW        = 16;
    localparam int unsigned RD_LAT    = 1;
    localparam int unsigned MAX_BURST = 4;

    localparam int MODE_ARB    = 0;
    localparam int MODE_DRAIN  = 1;
    localparam int MODE_LOCKED = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          c_req, c_we, c_gnt, c_rvalid;
    logic [AW-1:0] c_addr;
    logic [DW-1:0] c_wdata, c_rdata;
    logic          d_req, d_we, d_gnt, d_rvalid;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata, d_rdata;
    logic          d_lock, lock_ack;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic [15:0]   perf_stall;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .AW        (AW),
        .DW        (DW),
        .RD_LAT    (RD_LAT),
        .MAX_BURST (MAX_BURST)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .i_c_req      (c_req),
        .i_c_we       (c_we),
        .i_c_addr     (c_addr),
        .i_c_wdata    (c_wdata),
        .o_c_gnt      (c_gnt),
        .o_c_rvalid   (c_rvalid),
        .o_c_rdata    (c_rdata),
        .i_d_req      (d_req),
        .i_d_we       (d_we),
        .i_d_addr     (d_addr),
        .i_d_wdata    (d_wdata),
        .o_d_gnt      (d_gnt),
        .o_d_rvalid   (d_rvalid),
        .o_d_rdata    (d_rdata),
        .i_d_lock     (d_lock),
        .o_lock_ack   (lock_ack),
        .o_mem_en     (mem_en),
        .o_mem_we     (mem_we),
        .o_mem_addr   (mem_addr),
        .o_mem_wdata  (mem_wdata),
        .i_mem_rdata  (mem_rdata),
        .o_perf_stall (perf_stall)
    );

    // ---------------- bookkeeping ----------------
    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- memory model driven by the DUT port ----------------
    function automatic logic [DW-1:0] init_val(input int i);
        if (i == 16) return 16'hBEEF;
        return DW'(i * 4951) ^ 16'h5A5A;
    endfunction

    logic          mem_init;
    logic [DW-1:0] mem     [64];
    logic [DW-1:0] rd_pipe [RD_LAT];

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 64; i++) mem[i] <= init_val(i);
        end else if (mem_en && mem_we) begin
            mem[mem_addr[5:0]] <= mem_wdata;
        end
        rd_pipe[0] <= (mem_en && !mem_we) ? mem[mem_addr[5:0]] : 16'hDEAD;
        for (int i = 1; i < int'(RD_LAT); i++) rd_pipe[i] <= rd_pipe[i-1];
    end

    assign mem_rdata = rd_pipe[RD_LAT-1];

    // ---------------- reference model ----------------
    typedef struct {
        logic          own;   // 0 = C, 1 = D
        logic [DW-1:0] data;
        int            due;
    } rsp_t;

    rsp_t          sb[$];
    logic [DW-1:0] sh_mem [64];
    int            m_mode      = MODE_ARB;
    int            m_streak    = 0;       // C grants in a row while D waits
    int            m_last_due  = -1;      // cycle the newest read returns
    logic [15:0]   m_perf      = 16'd0;
    logic          m_gc, m_gd;
    int            last_cyc;
    logic          obs_c_gnt, obs_d_gnt, obs_lock_ack, obs_c_rvalid, obs_d_rvalid;
    logic [DW-1:0] obs_c_rdata;
    logic [15:0]   obs_perf;

    task automatic model_cycle();
        logic          gc, gd, ewe;
        logic [AW-1:0] ea;
        logic [DW-1:0] ewd;
        logic [15:0]   eperf;
        rsp_t          r;
        gc = 1'b0;
        gd = 1'b0;
        last_cyc = cyc;
        if (!rst) begin
            if (m_mode == MODE_ARB && !d_lock) begin
                if (c_req && !(d_req && m_streak == int'(MAX_BURST))) gc = 1'b1;
                else if (d_req) gd = 1'b1;
            end else if (m_mode == MODE_LOCKED) begin
                gd = d_req;
            end
        end
        ewe = gc ? c_we    : (gd ? d_we    : 1'b0);
        ea  = gc ? c_addr  : (gd ? d_addr  : '0);
        ewd = gc ? c_wdata : (gd ? d_wdata : '0);
`ifdef ARB_PERF_EN
        eperf = rst ? 16'd0 : m_perf;
`else
        eperf = 16'd0;
`endif
        check("c_gnt",      c_gnt,      gc);
        check("d_gnt",      d_gnt,      gd);
        check("mem_en",     mem_en,     gc | gd);
        check("mem_we",     mem_we,     ewe);
        check("mem_addr",   mem_addr,   ea);
        check("mem_wdata",  mem_wdata,  ewd);
        check("lock_ack",   lock_ack,   !rst && m_mode == MODE_LOCKED);
        check("perf_stall", perf_stall, eperf);

        obs_c_gnt    = c_gnt;
        obs_d_gnt    = d_gnt;
        obs_lock_ack = lock_ack;
        obs_c_rvalid = c_rvalid;
        obs_d_rvalid = d_rvalid;
        obs_c_rdata  = c_rdata;
        obs_perf     = perf_stall;
        m_gc = gc;
        m_gd = gd;

        if (rst) begin
            m_mode     = MODE_ARB;
            m_streak   = 0;
            m_last_due = -1;
            m_perf     = 16'd0;
            sb.delete();
        end else begin
            if (c_req && !gc && m_perf != 16'hFFFF) m_perf = m_perf + 16'd1;
            if (gd || !d_req) m_streak = 0;
            else if (gc && m_streak < int'(MAX_BURST)) m_streak++;
            if (gc || gd) begin
                if (ewe) begin
                    sh_mem[ea[5:0]] = ewd;
                end else begin
                    r.own  = gd;
                    r.data = sh_mem[ea[5:0]];
                    r.due  = cyc + int'(RD_LAT);
                    sb.push_back(r);
                    m_last_due = r.due;
                end
            end
            case (m_mode)
                MODE_ARB:    if (d_lock) m_mode = MODE_DRAIN;
                MODE_DRAIN:  if (!d_lock) m_mode = MODE_ARB;
                             else if (m_last_due < cyc) m_mode = MODE_LOCKED;
                default:     if (!d_lock) m_mode = MODE_ARB;
            endcase
        end
    endtask

    // ---------------- response monitor ----------------
    always @(negedge clk) begin
        rsp_t e;
        if (rst) begin
            check("rvalid_in_reset", {30'd0, c_rvalid, d_rvalid}, 32'd0);
        end else if (c_rvalid || d_rvalid) begin
            if (sb.size() == 0) begin
                check("unexpected_rvalid", {30'd0, c_rvalid, d_rvalid}, 32'd0);
            end else begin
                e = sb.pop_front();
                check("rvalid_pair", {30'd0, c_rvalid, d_rvalid}, {30'd0, ~e.own, e.own});
                check("rdata",       e.own ? d_rdata : c_rdata, e.data);
                check("other_rdata", e.own ? c_rdata : d_rdata, 32'd0);
                check("rsp_cycle",   cyc, e.due);
            end
        end else if (sb.size() > 0 && sb[0].due <= cyc) begin
            e = sb.pop_front();
            check("missing_rvalid", 32'd0, 32'd1);
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(negedge clk);
        model_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        c_req = 1'b0; c_we = 1'b0; c_addr = '0; c_wdata = '0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    endtask

    initial begin
        int          a_cyc, l_cyc, exp_lock, bound, lock_timer;
        logic [9:0]  pat_c, pat_d;
        logic [15:0] p0;

        for (int i = 0; i < 64; i++) sh_mem[i] = init_val(i);
        idle();
        d_lock   = 1'b0;
        rst      = 1'b1;
        mem_init = 1'b1;
        c_req    = 1'b1;   // requests during reset must not be granted
        d_req    = 1'b1;
        step();
        step();
        idle();
        rst      = 1'b0;
        mem_init = 1'b0;
        step();

        // C-only read of 0x0010 returning 0xBEEF
        c_req = 1'b1; c_we = 1'b0; c_addr = 16'h0010;
        step();
        check("t1_gnt", obs_c_gnt, 1);
        idle();
        for (int i = 0; i < int'(RD_LAT); i++) step();
        check("t1_rvalid", obs_c_rvalid, 1);
        check("t1_rdata",  obs_c_rdata, 16'hBEEF);
        check("t1_d_rvalid", obs_d_rvalid, 0);
        step();

        // Contention with both requesters holding reads
        c_req = 1'b1; c_addr = 16'h0003;
        d_req = 1'b1; d_addr = 16'h0004;
        for (int i = 0; i < 10; i++) begin
            step();
            pat_c[i] = obs_c_gnt;
            pat_d[i] = obs_d_gnt;
        end
        check("burst_c_seq", pat_c, 10'h1EF);
        check("burst_d_seq", pat_d, 10'h210);
        idle();
        for (int i = 0; i < int'(RD_LAT) + 1; i++) step();

        // Lock: C read, then d_lock with a pending D write and C still asking
        c_req = 1'b1; c_addr = 16'h0020;
        step();
        a_cyc = last_cyc;
        c_addr = 16'h0021;
        d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0022; d_wdata = 16'h1234;
        d_lock = 1'b1;
        step();
        l_cyc = last_cyc;
        check("lock_rise_no_gnt", {30'd0, obs_c_gnt, obs_d_gnt}, 0);
        exp_lock = ((l_cyc + 1) > (a_cyc + int'(RD_LAT) + 1) ?
                    (l_cyc + 1) : (a_cyc + int'(RD_LAT) + 1)) + 1;
        bound = 0;
        do begin
            step();
            bound++;
        end while (!obs_lock_ack && bound < 50);
        check("lock_reached", obs_lock_ack, 1);
        check("lock_latency", last_cyc, exp_lock);
        p0 = obs_perf;
        for (int i = 0; i < 5; i++) step();
`ifdef ARB_PERF_EN
        check("perf_locked_5", obs_perf - p0, 5);
`else
        check("perf_locked_0", obs_perf - p0, 0);
`endif
        // Unlock
        d_lock = 1'b0;
        step();
        check("unlock_ack_still", obs_lock_ack, 1);
        check("unlock_no_c", obs_c_gnt, 0);
        d_req = 1'b0;
        step();
        check("unlock_ack_fall", obs_lock_ack, 0);
        check("unlock_c_gnt", obs_c_gnt, 1);
        idle();
        for (int i = 0; i < int'(RD_LAT) + 1; i++) step();

        // Reset one cycle after a C read grant
        c_req = 1'b1; c_we = 1'b0; c_addr = 16'h0030;
        step();
        check("rst_pre_gnt", obs_c_gnt, 1);
        idle();
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < int'(RD_LAT) + 2; i++) step();
        check("rst_sb_empty", sb.size(), 0);

        // Randomized traffic
        lock_timer = 0;
        for (int n = 0; n < 3000; n++) begin
            if (!c_req || m_gc) begin
                c_req   = ($urandom_range(0, 3) != 0);
                c_we    = ($urandom_range(0, 2) == 0);
                c_addr  = AW'($urandom_range(0, 63));
                c_wdata = DW'($urandom);
            end
            if (!d_req || m_gd) begin
                d_req   = ($urandom_range(0, 2) == 0);
                d_we    = ($urandom_range(0, 1) == 0);
                d_addr  = AW'($urandom_range(0, 63));
                d_wdata = DW'($urandom);
            end
            if (lock_timer == 0) begin
                if ($urandom_range(0, 39) == 0) begin
                    d_lock     = 1'b1;
                    lock_timer = int'($urandom_range(2, 15));
                end
            end else begin
                lock_timer--;
                if (lock_timer == 0) d_lock = 1'b0;
            end
            rst = ($urandom_range(0, 299) == 0);
            step();
        end

        rst    = 1'b0;
        d_lock = 1'b0;
        idle();
        for (int i = 0; i < int'(RD_LAT) + 3; i++) step();
        check("final_sb_empty", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
